// File: rtl/soc1_sysid_pkg.sv
// Shared register map, CAPS layout and version packing for the SoC1 system-ID slave.
package soc1_sysid_pkg;

  localparam int unsigned OFS_ID        = 0;
  localparam int unsigned OFS_TIMESTAMP = 1;
  localparam int unsigned OFS_VERSION   = 2;
  localparam int unsigned OFS_SCRATCH   = 3;
  localparam int unsigned OFS_UPTIME_LO = 4;
  localparam int unsigned OFS_UPTIME_HI = 5;
  localparam int unsigned OFS_CAPS      = 6;
  localparam int unsigned OFS_CONTROL   = 7;
  localparam int unsigned OFS_USER0     = 8;

  localparam int CAPS_UPTIME_BIT = 0;
  localparam int CAPS_NUSER_LSB  = 4;
  localparam int CAPS_NUSER_MSB  = 7;
  localparam int CAPS_RDLAT_LSB  = 8;
  localparam int CAPS_RDLAT_MSB  = 10;

  localparam int CTRL_CLEAR_BIT  = 0;
  localparam int CTRL_FREEZE_BIT = 1;

  localparam logic [31:0] UNMAPPED_VALUE = 32'h0000_0000;

  function automatic logic [31:0] ver_word(input logic [7:0] major,
                                           input logic [7:0] minor,
                                           input logic [7:0] patch);
    return {8'h00, major, minor, patch};
  endfunction

endpackage

// File: rtl/soc1_sysid_if.sv
// Avalon-MM style bus bundle for the system-ID slave (no waitrequest, pipelined reads).
interface soc1_sysid_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/soc1_sysid_uptime.sv
// 64-bit free-running uptime counter with clear/freeze control and a HI shadow
// captured whenever the LO word is read, so LO/HI pairs are coherent.
module soc1_sysid_uptime (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        ctrl_wr,
  input  logic        freeze_d,
  input  logic        lo_rd,
  output logic [31:0] count_lo,
  output logic [31:0] shadow
);

  logic [63:0] count;
  logic        freeze;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      freeze <= 1'b0;
      shadow <= '0;
    end else begin
      // clear wins over freeze; the shadow is deliberately left alone
      if (clr)          count <= '0;
      else if (!freeze) count <= count + 64'd1;
      if (ctrl_wr) freeze <= freeze_d;
      if (lo_rd)   shadow <= count[63:32];
    end
  end

  assign count_lo = count[31:0];

endmodule

// File: rtl/soc1_sysid_ext.sv
// SoC1 system-ID slave: ID/timestamp/version/user words, SCRATCH, CAPS and
// fixed-latency pipelined reads. Define SOC1_SYSID_UPTIME_EN to add the uptime counter.
module soc1_sysid_ext
  import soc1_sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter logic [7:0]  VER_MAJOR    = 8'd2,
  parameter logic [7:0]  VER_MINOR    = 8'd0,
  parameter logic [7:0]  VER_PATCH    = 8'd0,
  parameter int          NUM_USER     = 4,
  parameter int          READ_LATENCY = 1,
  parameter int          ADDR_W       = 4,
  localparam int         USER_W       = (NUM_USER > 0) ? 32*NUM_USER : 32
) (
  input  logic              clock,
  input  logic              reset_n,
  soc1_sysid_if.slave       bus,
  input  logic [USER_W-1:0] user_id
);

  logic [ADDR_W-1:0] addr;
  logic [31:0]       addr_w;
  logic              rd_acc, wr_acc;
  logic [31:0]       scratch, caps, rd_word, up_lo, up_hi;

  assign addr   = bus.address;
  assign addr_w = 32'(addr);
  // a read in the same cycle as a write always wins
  assign rd_acc = bus.read;
  assign wr_acc = bus.write & ~bus.read;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch <= '0;
    end else if (wr_acc && (addr_w == OFS_SCRATCH)) begin
      for (int b = 0; b < 4; b++)
        if (bus.byteenable[b]) scratch[8*b +: 8] <= bus.writedata[8*b +: 8];
    end
  end

`ifdef SOC1_SYSID_UPTIME_EN
  localparam logic UP_PRESENT = 1'b1;
  logic ctrl_wr;
  // control bits live in byte lane 0
  assign ctrl_wr = wr_acc && (addr_w == OFS_CONTROL) && bus.byteenable[0];

  soc1_sysid_uptime u_uptime (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr      (ctrl_wr && bus.writedata[CTRL_CLEAR_BIT]),
    .ctrl_wr  (ctrl_wr),
    .freeze_d (bus.writedata[CTRL_FREEZE_BIT]),
    .lo_rd    (rd_acc && (addr_w == OFS_UPTIME_LO)),
    .count_lo (up_lo),
    .shadow   (up_hi)
  );
`else
  localparam logic UP_PRESENT = 1'b0;
  assign up_lo = '0;
  assign up_hi = '0;
`endif

  always_comb begin
    caps = '0;
    caps[CAPS_UPTIME_BIT]                = UP_PRESENT;
    caps[CAPS_NUSER_MSB:CAPS_NUSER_LSB]  = 4'(NUM_USER);
    caps[CAPS_RDLAT_MSB:CAPS_RDLAT_LSB]  = 3'(READ_LATENCY);
  end

  always_comb begin
    rd_word = UNMAPPED_VALUE;
    case (addr_w)
      OFS_ID:        rd_word = SYSTEM_ID;
      OFS_TIMESTAMP: rd_word = TIMESTAMP;
      OFS_VERSION:   rd_word = ver_word(VER_MAJOR, VER_MINOR, VER_PATCH);
      OFS_SCRATCH:   rd_word = scratch;
      OFS_UPTIME_LO: rd_word = up_lo;
      OFS_UPTIME_HI: rd_word = up_hi;
      OFS_CAPS:      rd_word = caps;
      default:       ;
    endcase
    for (int k = 0; k < NUM_USER; k++)
      if (addr_w == OFS_USER0 + k) rd_word = user_id[32*k +: 32];
  end

  // read pipeline: stage 0 is the accepted read, stage READ_LATENCY drives the bus
  logic [READ_LATENCY:1]         vld_q;
  logic [READ_LATENCY:0]         vld_pipe;
  logic [READ_LATENCY:1][31:0]   data_q;
  logic [READ_LATENCY:0][31:0]   data_pipe;

  assign vld_pipe  = {vld_q, rd_acc};
  assign data_pipe = {data_q, rd_word};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q <= vld_pipe[READ_LATENCY-1:0];
      // data only moves with a valid beat, so the output word holds between pulses
      for (int i = 1; i <= READ_LATENCY; i++)
        if (vld_pipe[i-1]) data_q[i] <= data_pipe[i-1];
    end
  end

  assign bus.readdatavalid = vld_pipe[READ_LATENCY];
  assign bus.readdata      = data_pipe[READ_LATENCY];

endmodule

// File: tb/tb_soc1_sysid_ext.sv
// Bench for soc1_sysid_ext: directed scenarios plus random traffic against a
// queue-based register model; honours SOC1_SYSID_UPTIME_EN like the design.
module tb_soc1_sysid_ext;
  localparam logic [31:0] SYS_ID = 32'h1234_5678;
  localparam logic [31:0] TSTAMP = 32'h6500_1234;
  localparam int RL = 3;
  localparam int NU = 4;
`ifdef SOC1_SYSID_UPTIME_EN
  localparam bit UP = 1'b1;
`else
  localparam bit UP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n;
  logic [32*NU-1:0] user_id;
  always #5 clock = ~clock;

  soc1_sysid_if #(.ADDR_W(4)) bus ();

  soc1_sysid_ext #(
    .SYSTEM_ID(SYS_ID), .TIMESTAMP(TSTAMP), .VER_MAJOR(8'd2), .VER_MINOR(8'd1),
    .VER_PATCH(8'd3), .NUM_USER(NU), .READ_LATENCY(RL), .ADDR_W(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus), .user_id(user_id)
  );

  int n_tests = 0, n_fail = 0;
  bit checking = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  int          q_due[$];
  logic [31:0] q_dat[$];
  logic [31:0] mlog[$], dlog[$];
  logic        exp_vld = 1'b0;
  logic [31:0] exp_dat = '0;
  logic [31:0] m_scratch = '0, m_shadow = '0;
  logic [63:0] m_cnt = '0, force_val = '0;
  bit          m_freeze = 1'b0, force_req = 1'b0;

  function automatic logic [31:0] model_rd(input int a);
    if (a >= 8 && a < 8 + NU) return user_id[32*(a-8) +: 32];
    case (a)
      0: return SYS_ID;
      1: return TSTAMP;
      2: return 32'h0002_0103;
      3: return m_scratch;
      4: return UP ? m_cnt[31:0] : 32'h0;
      5: return UP ? m_shadow : 32'h0;
      6: return UP ? 32'h0000_0341 : 32'h0000_0340;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_due.delete(); q_dat.delete();
      exp_vld = 1'b0; exp_dat = '0;
      m_scratch = '0; m_shadow = '0; m_cnt = '0; m_freeze = 1'b0;
    end else begin
      int a; bit clr, nfrz;
      cyc++;
      a = int'(bus.address);
      clr = 1'b0; nfrz = m_freeze;
      if (bus.read) begin
        q_dat.push_back(model_rd(a));
        q_due.push_back(cyc + RL - 1);
        if (UP && a == 4) m_shadow = m_cnt[63:32];
      end else if (bus.write) begin
        if (a == 3)
          for (int b = 0; b < 4; b++)
            if (bus.byteenable[b]) m_scratch[8*b +: 8] = bus.writedata[8*b +: 8];
        if (UP && a == 7 && bus.byteenable[0]) begin
          clr = bus.writedata[0]; nfrz = bus.writedata[1];
        end
      end
      if (UP) begin
        if (force_req)      m_cnt = force_val;
        else if (clr)       m_cnt = '0;
        else if (!m_freeze) m_cnt = m_cnt + 1;
        m_freeze = nfrz;
      end
      exp_vld = 1'b0;
      if (q_due.size() > 0 && q_due[0] == cyc) begin
        exp_vld = 1'b1;
        exp_dat = q_dat.pop_front();
        void'(q_due.pop_front());
        mlog.push_back(exp_dat);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(posedge clock); #1;
    if (checking) begin
      chk("readdatavalid", 32'(bus.readdatavalid), 32'(exp_vld));
      chk("readdata", bus.readdata, exp_dat);
      if (bus.readdatavalid) dlog.push_back(bus.readdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n = 1);
    repeat (n) begin @(negedge clock); bus.read = 1'b0; bus.write = 1'b0; end
  endtask
  task automatic rd(input int a);
    @(negedge clock); bus.read = 1'b1; bus.write = 1'b0; bus.address = 4'(a);
  endtask
  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clock);
    bus.read = 1'b0; bus.write = 1'b1; bus.address = 4'(a);
    bus.writedata = d; bus.byteenable = be;
  endtask

  initial begin
    int mb, db;
    bus.read = 1'b0; bus.write = 1'b0; bus.address = '0;
    bus.writedata = '0; bus.byteenable = '0;
    reset_n = 1'b1;
    for (int k = 0; k < NU; k++) user_id[32*k +: 32] = $urandom();
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checking = 1'b1;
    chk("reset_rdv", 32'(bus.readdatavalid), 32'h0);
    chk("reset_rdata", bus.readdata, 32'h0);
    @(negedge clock); reset_n = 1'b1;

    // back-to-back ID / TIMESTAMP / VERSION
    mb = mlog.size();
    rd(0); rd(1); rd(2); idle(RL + 2);
    chk("t1_count", 32'(mlog.size() - mb), 32'd3);
    chk("t1_id", mlog[mb], 32'h1234_5678);
    chk("t1_ts", mlog[mb+1], 32'h6500_1234);
    chk("t1_ver", mlog[mb+2], 32'h0002_0103);

    // SCRATCH byte-lane write
    mb = mlog.size();
    wr(3, 32'hFFFF_FFFF, 4'hF); wr(3, 32'h0000_00AA, 4'h1); rd(3); idle(RL + 2);
    chk("t2_scratch", mlog[mb], 32'hFFFF_FFAA);

`ifdef SOC1_SYSID_UPTIME_EN
    // coherent LO/HI across a low-word carry
    mb = mlog.size();
    @(negedge clock);
    bus.read = 1'b0; bus.write = 1'b0;
    force dut.u_uptime.count = 64'h0000_0007_FFFF_FFFE;
    force_val = 64'h0000_0007_FFFF_FFFE; force_req = 1'b1;
    @(negedge clock);
    release dut.u_uptime.count;
    force_req = 1'b0;
    bus.read = 1'b1; bus.address = 4'd4;
    idle(2); rd(5); idle(RL + 2);
    chk("t3_lo", mlog[mb], 32'hFFFF_FFFE);
    chk("t3_hi_shadow", mlog[mb+1], 32'h0000_0007);

    // freeze, then clear
    db = dlog.size();
    wr(7, 32'h2, 4'h1); idle(1); rd(4); idle(9); rd(4); idle(RL + 2);
    chk("t4_frozen_equal", dlog[db+1], dlog[db]);
    db = dlog.size();
    wr(7, 32'h1, 4'h1); rd(4); idle(RL + 2);
    chk("t4_after_clear_small", 32'(dlog[db] < RL + 4), 32'h1);
`endif

    // CAPS, unmapped, and uptime/CONTROL visibility
    mb = mlog.size();
    rd(6); rd(15); wr(7, 32'h3, 4'hF); rd(4); rd(5); idle(RL + 2);
    chk("t6_caps", mlog[mb], UP ? 32'h0000_0341 : 32'h0000_0340);
    chk("t6_unmapped", mlog[mb+1], 32'h0);
`ifndef SOC1_SYSID_UPTIME_EN
    chk("t6_up_lo_zero", mlog[mb+2], 32'h0);
    chk("t6_up_hi_zero", mlog[mb+3], 32'h0);
`endif

    // reset in the middle of a read burst
    db = dlog.size();
    rd(8); rd(9); rd(10);
    @(negedge clock); reset_n = 1'b0; bus.address = 4'd11;
    @(negedge clock);
    chk("t5_rst_rdata", bus.readdata, 32'h0);
    chk("t5_rst_rdv", 32'(bus.readdatavalid), 32'h0);
    @(negedge clock); reset_n = 1'b1; bus.read = 1'b0;
    idle(RL + 2);
    chk("t5_pulses", 32'(dlog.size() - db), 32'd1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      if ($urandom_range(0, 599) == 0) begin
        reset_n = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        @(negedge clock); reset_n = 1'b1;
      end else begin
        bus.read       = ($urandom_range(0, 1) == 1);
        bus.write      = ($urandom_range(0, 2) == 0);
        bus.address    = 4'($urandom_range(0, 15));
        bus.writedata  = $urandom();
        bus.byteenable = 4'($urandom_range(0, 15));
      end
    end
    idle(RL + 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
